// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and ALU-op encodings for the multicycle controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;

    // Instruction class latched at DECODE; steers EXECUTE/MEM sequencing.
    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } cls_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b0110;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational RV32 subset decoder (R, I-ALU, load, store, BEQ/BNE)
//   ir       in   instruction register
//   cls      out  instruction class
//   rs1/rs2/rd out register indices (rs2 forced 0 for I-type and loads)
//   imm      out  sign-extended immediate for the class
//   alu_op   out  ALU operation code
//   alu_src  out  1 = immediate operand
//   wb_sel   out  1 = write back load data
//   illegal  out  unsupported opcode or funct combination
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic [31:0]         ir,
    output cls_e                cls,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                wb_sel,
    output logic                illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [3:0]      op4;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rd     = ir[11:7];

    assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    assign alu_op = ALU_OP_W'(op4);

    always_comb begin
        cls     = CLS_R;
        rs2     = ir[24:20];
        imm     = '0;
        op4     = ALU_NOP;
        alu_src = 1'b0;
        wb_sel  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                cls = CLS_R;
                case ({funct7, funct3})
                    10'b0000000_000: op4 = ALU_ADD;
                    10'b0100000_000: op4 = ALU_SUB;
                    10'b0000000_100: op4 = ALU_XOR;
                    10'b0000000_110: op4 = ALU_OR;
                    10'b0000000_111: op4 = ALU_AND;
                    default:         illegal = 1'b1;
                endcase
            end
            OP_I: begin
                cls     = CLS_I;
                rs2     = 5'd0;
                imm     = imm_i;
                alu_src = 1'b1;
                case (funct3)
                    3'b000:  op4 = ALU_ADD;
                    3'b100:  op4 = ALU_XOR;
                    3'b110:  op4 = ALU_OR;
                    3'b111:  op4 = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                cls     = CLS_LOAD;
                rs2     = 5'd0;
                imm     = imm_i;
                op4     = ALU_ADD;
                alu_src = 1'b1;
                wb_sel  = 1'b1;
                illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                cls     = CLS_STORE;
                imm     = imm_s;
                op4     = ALU_ADD;
                alu_src = 1'b1;
                illegal = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                cls     = CLS_BRANCH;
                imm     = imm_b;
                op4     = ALU_SUB;
                // Only BEQ (000) and BNE (001) are supported.
                illegal = (funct3[2:1] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXECUTE/MEM/WB control FSM and PC
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/addr/ready/rdata  instruction fetch handshake
//   dmem_req/we/funct3/ready   data access handshake
//   alu_zero              ALU result is zero (branch compare)
//   alu_op/alu_src/imm    ALU controls and immediate
//   rs1/rs2/rd/rf_we/wb_sel  register file controls
//   pc/illegal/state      program counter, sticky illegal flag, FSM state
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [2:0]          dmem_funct3,
    input  logic                dmem_ready,
    input  logic                alu_zero,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic [XLEN-1:0]     imm,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic                rf_we,
    output logic                wb_sel,
    output logic [XLEN-1:0]     pc,
    output logic                illegal,
    output logic [2:0]          state
);

    state_e                state_q;
    cls_e                  cls_q;
    logic [31:0]           ir_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       imm_q;
    logic [4:0]            rs1_q, rs2_q, rd_q;
    logic [ALU_OP_W-1:0]   alu_op_q;
    logic                  alu_src_q, wb_sel_q, illegal_q;

    cls_e                  dec_cls;
    logic [4:0]            dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0]       dec_imm;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic                  dec_alu_src, dec_wb_sel, dec_illegal;

    logic [XLEN-1:0]       pc_plus4;
    logic                  branch_taken;

    instr_decode #(
        .XLEN     (XLEN),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .ir      (ir_q),
        .cls     (dec_cls),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .imm     (dec_imm),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .wb_sel  (dec_wb_sel),
        .illegal (dec_illegal)
    );

    // Additions wrap naturally modulo 2^XLEN.
    assign pc_plus4     = pc_q + XLEN'(4);
    // ir[12] separates BNE (1) from BEQ (0).
    assign branch_taken = ir_q[12] ? ~alu_zero : alu_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= CLS_R;
            ir_q      <= '0;
            pc_q      <= RESET_PC;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alu_op_q  <= ALU_OP_W'(ALU_NOP);
            alu_src_q <= 1'b0;
            wb_sel_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_TRAP;
                    end else begin
                        cls_q     <= dec_cls;
                        rs1_q     <= dec_rs1;
                        rs2_q     <= dec_rs2;
                        rd_q      <= dec_rd;
                        imm_q     <= dec_imm;
                        alu_op_q  <= dec_alu_op;
                        alu_src_q <= dec_alu_src;
                        wb_sel_q  <= dec_wb_sel;
                        state_q   <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (cls_q)
                        CLS_LOAD, CLS_STORE: state_q <= S_MEM;
                        CLS_BRANCH: begin
                            pc_q    <= branch_taken ? (pc_q + imm_q) : pc_plus4;
                            state_q <= S_FETCH;
                        end
                        default: state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls_q == CLS_STORE) begin
                            pc_q    <= pc_plus4;
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc_q    <= pc_plus4;
                    state_q <= S_FETCH;
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Requests and the write strobe are masked by rst_n so an access in flight
    // is dropped the moment reset is asserted, not one edge later.
    assign imem_req    = rst_n && (state_q == S_FETCH);
    assign dmem_req    = rst_n && (state_q == S_MEM);
    assign dmem_we     = dmem_req && (cls_q == CLS_STORE);
    assign rf_we       = rst_n && (state_q == S_WB) && (rd_q != 5'd0);
    assign imem_addr   = pc_q;
    assign dmem_funct3 = ir_q[14:12];
    assign alu_op      = alu_op_q;
    assign alu_src     = alu_src_q;
    assign imm         = imm_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign wb_sel      = wb_sel_q;
    assign pc          = pc_q;
    assign illegal     = illegal_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  dmem_funct3;
    logic        dmem_ready;
    logic        alu_zero;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rf_we;
    logic        wb_sel;
    logic [31:0] pc;
    logic        illegal;
    logic [2:0]  state;

    int checks = 0;
    int passed = 0;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_funct3 (dmem_funct3),
        .dmem_ready  (dmem_ready),
        .alu_zero    (alu_zero),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .imm         (imm),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .pc          (pc),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          zero;
        int          dwait;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        bit          chk_imm;
        logic [3:0]  aop;
        bit          asrc;
        bit          wsel;
        int          we;
        int          cyc;
        int          dcyc;
        bit          dwe;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        bit          timeout;
        bit          overlap;
        int          cycles;
        int          we_cnt;
        int          dcyc;
        bit          dwe;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  aop;
        bit          asrc;
        bit          wsel;
        logic [31:0] pc;
    } obs_t;

    vec_t exp_q[$];

    function automatic vec_t v(input logic [31:0] instr, input bit zero, input int dwait,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdx,
                               input logic [31:0] im, input bit chk_imm, input logic [3:0] aop,
                               input bit asrc, input bit wsel, input int we, input int cyc,
                               input int dcyc, input bit dwe, input logic [31:0] pcn);
        vec_t t;
        t.instr = instr; t.zero = zero; t.dwait = dwait;
        t.rs1 = r1; t.rs2 = r2; t.rd = rdx; t.imm = im; t.chk_imm = chk_imm;
        t.aop = aop; t.asrc = asrc; t.wsel = wsel; t.we = we; t.cyc = cyc;
        t.dcyc = dcyc; t.dwe = dwe; t.pc = pcn;
        return t;
    endfunction

    // Plays instruction and data memory for one instruction, from the FETCH
    // handshake until the FSM is back in FETCH (or parks in TRAP).
    task automatic exec(input logic [31:0] instr, input bit zero, input int dwait, output obs_t o);
        int guard;
        int dc;
        o = '{default: 0};
        alu_zero = zero;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!imem_req) begin
            o.timeout = 1'b1;
            return;
        end
        imem_rdata = instr;
        imem_ready = 1'b1;
        o.cycles = 1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        dc = 0;
        guard = 0;
        while (state != 3'd0 && state != 3'd5 && guard < 60) begin
            o.cycles++;
            if (imem_req && dmem_req) o.overlap = 1'b1;
            dmem_ready = 1'b0;
            if (dmem_req) begin
                dc++;
                o.dwe = dmem_we;
                dmem_ready = (dc > dwait);
            end
            if (rf_we) o.we_cnt++;
            @(posedge clk); #1;
            guard++;
        end
        dmem_ready = 1'b0;
        if (guard >= 60) o.timeout = 1'b1;
        o.dcyc = dc;
        o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.imm = imm;
        o.aop = alu_op; o.asrc = alu_src; o.wsel = wb_sel; o.pc = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d exp 0", state); else passed++;
        checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp 00000000", pc); else passed++;
        checks++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req got %b exp 0", imem_req); else passed++;
        checks++; if ({dmem_req, dmem_we, rf_we} !== 3'b000) $display("FAIL reset_strobes got %b exp 000", {dmem_req, dmem_we, rf_we}); else passed++;
        checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", illegal); else passed++;
        checks++; if (alu_op !== 4'b0110) $display("FAIL reset_alu_op got %b exp 0110", alu_op); else passed++;
        checks++; if ({imm, rs1, rs2, rd, alu_src, wb_sel} !== 49'd0) $display("FAIL reset_fields got %h exp 0", {imm, rs1, rs2, rd, alu_src, wb_sel}); else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if ({state, imem_req} !== {3'd0, 1'b1}) $display("FAIL release_fetch got state=%0d req=%b exp state=0 req=1", state, imem_req); else passed++;
    endtask

    // Instruction stream run back to back; instr 0 in the table stands for a reset pulse.
    task automatic test_instr_stream();
        vec_t tbl[$];
        vec_t e;
        obs_t o;
        tbl.push_back(v(32'h002081B3, 0, 0, 1, 2, 3,  0, 0, 4'b0000, 0, 0, 1, 4, 0, 0, 32'h04)); // ADD x3,x1,x2
        tbl.push_back(v(32'h404183B3, 0, 0, 3, 4, 7,  0, 0, 4'b0001, 0, 0, 1, 4, 0, 0, 32'h08)); // SUB x7,x3,x4
        tbl.push_back(v(32'h0020F433, 0, 0, 1, 2, 8,  0, 0, 4'b1000, 0, 0, 1, 4, 0, 0, 32'h0C)); // AND x8
        tbl.push_back(v(32'h0020C4B3, 0, 0, 1, 2, 9,  0, 0, 4'b1100, 0, 0, 1, 4, 0, 0, 32'h10)); // XOR x9
        tbl.push_back(v(32'hFFF0E513, 0, 0, 1, 0, 10, 32'hFFFFFFFF, 1, 4'b1001, 1, 0, 1, 4, 0, 0, 32'h14)); // ORI x10,x1,-1
        tbl.push_back(v(32'h00208033, 0, 0, 1, 2, 0,  0, 0, 4'b0000, 0, 0, 0, 4, 0, 0, 32'h18)); // ADD x0: no write
        tbl.push_back(v(32'hFFC12283, 0, 3, 2, 0, 5,  32'hFFFFFFFC, 1, 4'b0000, 1, 1, 1, 8, 4, 0, 32'h1C)); // LW x5,-4(x2)
        tbl.push_back(v(32'h00612423, 0, 0, 2, 6, 8,  32'h8, 1, 4'b0000, 1, 0, 0, 4, 1, 1, 32'h20)); // SW x6,8(x2)
        tbl.push_back(v(32'h0000C583, 0, 1, 1, 0, 11, 32'h0, 1, 4'b0000, 1, 1, 1, 6, 2, 0, 32'h24)); // LBU x11,0(x1)
        tbl.push_back(v(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(v(32'h00500093, 0, 0, 0, 0, 1, 32'h5, 1, 4'b0000, 1, 0, 1, 4, 0, 0, 32'(4 * i))); // ADDI x1,x0,5
        tbl.push_back(v(32'h00208863, 0, 0, 1, 2, 16, 32'h10, 1, 4'b0001, 0, 0, 0, 3, 0, 0, 32'h14)); // BEQ +16 not taken
        tbl.push_back(v(32'hFE209EE3, 0, 0, 1, 2, 29, 32'hFFFFFFFC, 1, 4'b0001, 0, 0, 0, 3, 0, 0, 32'h10)); // BNE -4 taken
        tbl.push_back(v(32'h00208863, 1, 0, 1, 2, 16, 32'h10, 1, 4'b0001, 0, 0, 0, 3, 0, 0, 32'h20)); // BEQ +16 taken
        tbl.push_back(v(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(32'hFE000EE3, 1, 0, 0, 0, 29, 32'hFFFFFFFC, 1, 4'b0001, 0, 0, 0, 3, 0, 0, 32'hFFFFFFFC)); // BEQ x0,x0,-4
        tbl.push_back(v(32'h00500093, 0, 0, 0, 0, 1, 32'h5, 1, 4'b0000, 1, 0, 1, 4, 0, 0, 32'h0)); // ADDI wraps pc
        foreach (tbl[k]) begin
            if (tbl[k].instr == 32'h0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                continue;
            end
            exp_q.push_back(tbl[k]);
            exec(tbl[k].instr, tbl[k].zero, tbl[k].dwait, o);
            e = exp_q.pop_front();
            checks++; if (o.timeout) $display("FAIL i%0d_timeout instr=%h got timeout exp completion", k, e.instr); else passed++;
            checks++; if (o.overlap) $display("FAIL i%0d_req_overlap got 1 exp 0", k); else passed++;
            checks++; if ({o.rs1, o.rs2, o.rd} !== {e.rs1, e.rs2, e.rd}) $display("FAIL i%0d_regs got %0d/%0d/%0d exp %0d/%0d/%0d", k, o.rs1, o.rs2, o.rd, e.rs1, e.rs2, e.rd); else passed++;
            if (e.chk_imm) begin
                checks++; if (o.imm !== e.imm) $display("FAIL i%0d_imm got %h exp %h", k, o.imm, e.imm); else passed++;
            end
            checks++; if (o.aop !== e.aop) $display("FAIL i%0d_alu_op got %b exp %b", k, o.aop, e.aop); else passed++;
            checks++; if ({o.asrc, o.wsel} !== {e.asrc, e.wsel}) $display("FAIL i%0d_src_sel got %b%b exp %b%b", k, o.asrc, o.wsel, e.asrc, e.wsel); else passed++;
            checks++; if (o.we_cnt != e.we) $display("FAIL i%0d_rf_we_count got %0d exp %0d", k, o.we_cnt, e.we); else passed++;
            checks++; if (o.cycles != e.cyc) $display("FAIL i%0d_latency got %0d exp %0d", k, o.cycles, e.cyc); else passed++;
            checks++; if (o.dcyc != e.dcyc || o.dwe != e.dwe) $display("FAIL i%0d_dmem got cyc=%0d we=%b exp cyc=%0d we=%b", k, o.dcyc, o.dwe, e.dcyc, e.dwe); else passed++;
            checks++; if (o.pc !== e.pc) $display("FAIL i%0d_pc got %h exp %h", k, o.pc, e.pc); else passed++;
        end
    endtask

    task automatic test_trap();
        obs_t o;
        bit bad;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exec(32'h00500093, 0, 0, o);
        exec(32'h0000007F, 0, 0, o);
        checks++; if ({state, illegal} !== {3'd5, 1'b1}) $display("FAIL trap_enter got state=%0d ill=%b exp state=5 ill=1", state, illegal); else passed++;
        bad = 1'b0;
        imem_rdata = 32'h002081B3;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (imem_req || dmem_req || rf_we || illegal !== 1'b1 || state !== 3'd5 || pc !== 32'h4) bad = 1'b1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        checks++; if (bad) $display("FAIL trap_sticky got activity or pc=%h exp quiet, pc=00000004", pc); else passed++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({pc, illegal, state} !== {32'h0, 1'b0, 3'd0}) $display("FAIL trap_reset got pc=%h ill=%b st=%0d exp pc=0 ill=0 st=0", pc, illegal, state); else passed++;
        rst_n = 1'b1;
        exec(32'h0000B003, 0, 0, o); // load funct3 011 is not in the supported set
        checks++; if ({state, illegal} !== {3'd5, 1'b1}) $display("FAIL trap_bad_funct3 got state=%0d ill=%b exp state=5 ill=1", state, illegal); else passed++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        int guard;
        bit bad;
        guard = 0;
        while (!imem_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        imem_rdata = 32'h00612423;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        guard = 0;
        while (!dmem_req && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++; if (dmem_req !== 1'b1) $display("FAIL midmem_reach got dmem_req=%b exp 1", dmem_req); else passed++;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) $display("FAIL midmem_abort got dmem_req=%b exp 0", dmem_req); else passed++;
        @(posedge clk); #1;
        checks++; if ({state, pc} !== {3'd0, 32'h0}) $display("FAIL midmem_reset got st=%0d pc=%h exp st=0 pc=0", state, pc); else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if ({state, imem_req} !== {3'd0, 1'b1}) $display("FAIL midmem_release got st=%0d req=%b exp st=0 req=1", state, imem_req); else passed++;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (dmem_req || rf_we || state !== 3'd0) bad = 1'b1;
        end
        checks++; if (bad) $display("FAIL midmem_no_wb got activity exp idle FETCH"); else passed++;
    endtask

    initial begin
        test_reset();
        test_instr_stream();
        test_trap();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC/immediate width (>=32).
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-003 SHALL have parameter ALU_OP_W, default 4, meaning alu_op width.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning); one clock, reset synchronous active-low:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  synchronous active-low reset
 imem_req  out  1  instruction fetch request
 imem_addr  out  XLEN  fetch address (= pc)
 imem_ready  in  1  fetch data valid this cycle
 imem_rdata  in  32  fetched instruction
 dmem_req  out  1  data access request
 dmem_we  out  1  1 = store, 0 = load
 dmem_funct3  out  3  access size/sign (funct3 passthrough)
 dmem_ready  in  1  data access complete this cycle
 alu_zero  in  1  ALU result == 0
 alu_op  out  ALU_OP_W  ALU operation code
 alu_src  out  1  0 = rs2 operand, 1 = imm operand
 imm  out  XLEN  sign-extended immediate
 rs1, rs2, rd  out  5 each  register indices
 rf_we  out  1  register-file write strobe (one cycle)
 wb_sel  out  1  0 = ALU result, 1 = load data
 pc  out  XLEN  current program counter
 illegal  out  1  sticky illegal-instruction flag
 state  out  3  current FSM state (debug)

Function
REQ-005 SHALL implement FSM states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6-7 unreachable and SHALL return to FETCH.
REQ-006 FETCH: imem_req=1, imem_addr=pc; stay while imem_ready=0; on imem_ready=1 latch imem_rdata into internal ir, go DECODE.
REQ-007 DECODE (1 cycle): register rs1=ir[19:15], rd=ir[11:7], rs2=ir[24:20] (0 for I-type/load), imm, alu_op, alu_src, wb_sel; all held stable until next DECODE.
REQ-008 Immediates, sign-extended to XLEN: I/load {ir[31:20]}; S {ir[31:25],ir[11:7]}; B {ir[31],ir[7],ir[30:25],ir[11:8],1'b0}.
REQ-009 Opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch (BEQ funct3=000, BNE 001 only).
REQ-010 alu_op: ADD 0000, SUB 0001, AND 1000, OR 1001, XOR 1100, NOP 0110; R {funct7,funct3} and I funct3 mapping as ADD/SUB/XOR/OR/AND(I: ADDI/XORI/ORI/ANDI); load/store = ADD (address calc); branch = SUB.
REQ-011 Any other opcode, unsupported funct combo, or funct3 outside load {000,001,010,100,101}/store {000,001,010}/branch set -> DECODE goes TRAP, illegal=1; no X ever driven.
REQ-012 EXECUTE (1 cycle): R/I -> WB; load/store -> MEM; branch -> FETCH with pc = pc+imm if taken (BEQ alu_zero=1, BNE alu_zero=0) else pc+4.
REQ-013 MEM: dmem_req=1, dmem_we=1 for store, dmem_funct3=ir[14:12]; hold while dmem_ready=0; on dmem_ready load -> WB, store -> FETCH with pc+=4.
REQ-014 WB (1 cycle): rf_we=1 for exactly this cycle, pc+=4, go FETCH; rf_we SHALL never assert with rd=0.
REQ-015 PC arithmetic modulo 2^XLEN; wrap from max to 0 without flag.
REQ-016 TRAP: all request/strobe outputs 0, pc frozen, remains until reset.
REQ-017 Latency: R/I = 4 cycles with zero-wait memory; load 5; store 4; branch 3.
REQ-018 imem_req and dmem_req SHALL never be asserted in the same cycle.

Reset
REQ-019 rst_n=0 sampled on clk: state=FETCH, pc=RESET_PC, ir=0, illegal=0, imm=0, rs1/rs2/rd=0, alu_op=NOP, alu_src=0, wb_sel=0, rf_we=0, dmem_req=0, dmem_we=0, imem_req=0 during reset.
REQ-020 Reset mid-access (FETCH/MEM waiting) SHALL abort without writeback; first cycle after release is FETCH with imem_req=1.

Structure
REQ-021 Opcode, ALU-op codes and state encodings SHALL live in shared package ctrl_pkg.
REQ-022 Combinational decode (REQ-007..011) SHALL be sub-module instr_decode; FSM/PC in top.

Verification
REQ-023 ADD x3,x1,x2 (0x002081B3), imem_ready immediate -> rs1=1,rs2=2,rd=3,alu_op=0000, rf_we pulse 4th cycle, pc 0->4.
REQ-024 LW x5,-4(x2), dmem_ready delayed 3 cycles -> imm=0xFFFFFFFC, dmem_req held 4 cycles, wb_sel=1, rf_we once.
REQ-025 BEQ offset +16, alu_zero=1 -> pc 0x10->0x20; alu_zero=0 -> 0x14; rf_we never asserted.
REQ-026 Opcode 1111111 -> TRAP, illegal=1 sticky, imem_req=0 until rst_n=0 then pc=RESET_PC.
REQ-027 rst_n low during MEM wait of SW -> no further dmem_req, state=FETCH, pc=RESET_PC.
REQ-028 pc=0xFFFFFFFC, ADDI executed -> pc wraps to 0x0.
